// File: rtl/clock_div_ctrl.sv
// Programmable clock divider: divides clk by cur_div with a glitch-free
// registered output, a period tick, and a req/ack handshake for ratio changes.
module clock_div_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             div_req,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             div_busy,
  output logic [WIDTH-1:0] cur_div,
  output logic             clk_out,
  output logic             tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(32'd2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  // High-phase length ceil(d/2); one extra bit so d = 2^WIDTH-1 cannot overflow.
  function automatic logic [WIDTH:0] half_up(input logic [WIDTH-1:0] d);
    half_up = ({1'b0, d} + {ZERO, 1'b1}) >> 1'b1;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] cur_div_r, cur_div_s;
  logic [WIDTH-1:0] pend_r, pend_s;
  logic             clk_out_r, clk_out_s;
  logic             tick_r, tick_s;
  logic             ack_r, ack_s;
  logic             err_r, err_s;
  logic             busy_r, busy_s;

  logic [WIDTH-1:0] next_cnt_s;
  logic [WIDTH:0]   hi_s;
  logic             last_s;
  logic             wrap_s;
  logic             accept_s;
  logic             bad_s;
  logic             apply_s;

  // Free-running period counter helpers shared by RUN and STOP.
  always_comb begin
    last_s     = (cnt_r == (cur_div_r - ONE));
    next_cnt_s = last_s ? ZERO : (cnt_r + ONE);
    hi_s       = half_up(cur_div_r);
  end

  // Next-state and divided-clock generation.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    clk_out_s = clk_out_r;
    tick_s    = 1'b0;
    wrap_s    = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s     = ZERO;
        clk_out_s = 1'b0;
        if (enable) begin
          state_s   = RUN;
          clk_out_s = 1'b1;
          tick_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        cnt_s     = next_cnt_s;
        clk_out_s = ({1'b0, next_cnt_s} < hi_s);
        tick_s    = last_s;
        wrap_s    = last_s;
        if (!enable) begin
          state_s = STOP;
        end else begin
          state_s = RUN;
        end
      end
      STOP: begin
        wrap_s = last_s;
        // A returning enable simply resumes counting; otherwise park at the wrap.
        if (enable) begin
          state_s   = RUN;
          cnt_s     = next_cnt_s;
          clk_out_s = ({1'b0, next_cnt_s} < hi_s);
          tick_s    = last_s;
        end else if (last_s) begin
          state_s   = IDLE;
          cnt_s     = ZERO;
          clk_out_s = 1'b0;
          tick_s    = 1'b0;
        end else begin
          state_s   = STOP;
          cnt_s     = next_cnt_s;
          clk_out_s = ({1'b0, next_cnt_s} < hi_s);
          tick_s    = 1'b0;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_s     = ZERO;
        clk_out_s = 1'b0;
        tick_s    = 1'b0;
      end
    endcase
  end

  // Ratio handshake; busy_r is registered, so a wrap on the accept edge never applies.
  always_comb begin
    accept_s  = div_req & ~busy_r & ~ack_r;
    bad_s     = (div_val < DIV_MIN);
    ack_s     = accept_s;
    err_s     = accept_s & bad_s;
    apply_s   = busy_r & (wrap_s | (state_r == IDLE));
    pend_s    = pend_r;
    busy_s    = busy_r;
    cur_div_s = cur_div_r;
    if (apply_s) begin
      cur_div_s = pend_r;
      busy_s    = 1'b0;
    end else if (accept_s && !bad_s) begin
      pend_s = div_val;
      busy_s = 1'b1;
    end else begin
      busy_s = busy_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_r   <= IDLE;
      cnt_r     <= ZERO;
      cur_div_r <= DIV_RST;
      pend_r    <= ZERO;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      cur_div_r <= cur_div_s;
      pend_r    <= pend_s;
      clk_out_r <= clk_out_s;
      tick_r    <= tick_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
      busy_r    <= busy_s;
    end
  end

  assign div_ack  = ack_r;
  assign div_err  = err_r;
  assign div_busy = busy_r;
  assign cur_div  = cur_div_r;
  assign clk_out  = clk_out_r;
  assign tick     = tick_r;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed self-checking bench for clock_div_ctrl: default ratio, handshake
// accept/reject/hold, disable, async clear and extreme divisors.
module tb_clock_div_ctrl;

  logic       clk;
  logic       clear;
  logic       enable;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack;
  logic       div_err;
  logic       div_busy;
  logic [7:0] cur_div;
  logic       clk_out;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;

  clock_div_ctrl #(.WIDTH(8), .DIV_RESET(5)) dut (
    .clk     (clk),
    .clear   (clear),
    .enable  (enable),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .div_busy(div_busy),
    .cur_div (cur_div),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Observation must start at the first cycle of a period.
  task automatic check_period(input int n, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_val($sformatf("clk_out_n%0d_i%0d", n, i), {31'd0, clk_out}, ((i % n) < ((n + 1) / 2)) ? 32'd1 : 32'd0);
      check_val($sformatf("tick_n%0d_i%0d", n, i), {31'd0, tick}, ((i % n) == 0) ? 32'd1 : 32'd0);
      step();
    end
  endtask

  task automatic check_hs(input string tag, input logic a, input logic e, input logic b, input int cd);
    check_val({tag, "_ack"}, {31'd0, div_ack}, {31'd0, a});
    check_val({tag, "_err"}, {31'd0, div_err}, {31'd0, e});
    check_val({tag, "_busy"}, {31'd0, div_busy}, {31'd0, b});
    check_val({tag, "_cur"}, {24'd0, cur_div}, cd);
  endtask

  initial begin
    clear   = 1'b0;
    enable  = 1'b0;
    div_req = 1'b0;
    div_val = 8'd0;
    @(negedge clk);
    step();
    // Reset values
    check_hs("rst", 1'b0, 1'b0, 1'b0, 5);
    check_val("rst_clk_out", {31'd0, clk_out}, 32'd0);
    check_val("rst_tick", {31'd0, tick}, 32'd0);
    clear = 1'b1;
    step();
    check_val("idle_clk_out", {31'd0, clk_out}, 32'd0);

    // Default N=5
    enable = 1'b1;
    step();
    check_hs("run5", 1'b0, 1'b0, 1'b0, 5);
    check_period(5, 10);

    // Rejected requests (1 then 0)
    div_req = 1'b1; div_val = 8'd1;
    step();
    check_hs("rej1", 1'b1, 1'b1, 1'b0, 5);
    div_req = 1'b0;
    step();
    check_hs("rej1_after", 1'b0, 1'b0, 1'b0, 5);
    div_req = 1'b1; div_val = 8'd0;
    step();
    check_hs("rej0", 1'b1, 1'b1, 1'b0, 5);
    div_req = 1'b0;
    step();
    check_hs("rej0_after", 1'b0, 1'b0, 1'b0, 5);
    step();
    check_period(5, 5);

    // Disable at cnt=2
    step();
    step();
    check_val("dis_c2_clk", {31'd0, clk_out}, 32'd1);
    enable = 1'b0;
    step();
    check_val("dis_c3_clk", {31'd0, clk_out}, 32'd0);
    step();
    check_val("dis_c4_clk", {31'd0, clk_out}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val($sformatf("idle_clk_%0d", i), {31'd0, clk_out}, 32'd0);
      check_val($sformatf("idle_tick_%0d", i), {31'd0, tick}, 32'd0);
    end
    enable = 1'b1;
    step();
    check_period(5, 5);

    // Request 4 at cnt=1
    step();
    div_req = 1'b1; div_val = 8'd4;
    step();
    check_hs("req4", 1'b1, 1'b0, 1'b1, 5);
    check_val("req4_c2_clk", {31'd0, clk_out}, 32'd1);
    div_req = 1'b0;
    step();
    check_hs("req4_c3", 1'b0, 1'b0, 1'b1, 5);
    check_val("req4_c3_clk", {31'd0, clk_out}, 32'd0);
    step();
    check_val("req4_c4_clk", {31'd0, clk_out}, 32'd0);
    check_val("req4_c4_busy", {31'd0, div_busy}, 32'd1);
    step();
    check_hs("app4", 1'b0, 1'b0, 1'b0, 4);
    check_period(4, 8);

    // Pending 3 while 7 is held
    div_req = 1'b1; div_val = 8'd3;
    step();
    check_hs("req3", 1'b1, 1'b0, 1'b1, 4);
    div_req = 1'b0;
    step();
    div_req = 1'b1; div_val = 8'd7;
    step();
    check_hs("hold7", 1'b0, 1'b0, 1'b1, 4);
    step();
    check_hs("app3", 1'b0, 1'b0, 1'b0, 3);
    check_val("app3_clk", {31'd0, clk_out}, 32'd1);
    check_val("app3_tick", {31'd0, tick}, 32'd1);
    step();
    check_hs("acc7", 1'b1, 1'b0, 1'b1, 3);
    check_val("n3_c1_clk", {31'd0, clk_out}, 32'd1);
    div_req = 1'b0;
    step();
    check_val("n3_c2_clk", {31'd0, clk_out}, 32'd0);
    check_val("n3_c2_tick", {31'd0, tick}, 32'd0);
    step();
    check_hs("app7", 1'b0, 1'b0, 1'b0, 7);
    check_period(7, 14);

    // Async clear with a request pending
    div_req = 1'b1; div_val = 8'd2;
    step();
    check_hs("req2_pre", 1'b1, 1'b0, 1'b1, 7);
    div_req = 1'b0;
    step();
    enable = 1'b0;
    clear  = 1'b0;
    #1;
    check_hs("clr", 1'b0, 1'b0, 1'b0, 5);
    check_val("clr_clk_out", {31'd0, clk_out}, 32'd0);
    check_val("clr_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    clear = 1'b1;
    step();
    check_hs("post_clr", 1'b0, 1'b0, 1'b0, 5);

    // N=2 applied while idle
    div_req = 1'b1; div_val = 8'd2;
    step();
    check_hs("req2", 1'b1, 1'b0, 1'b1, 5);
    div_req = 1'b0;
    step();
    check_hs("app2_idle", 1'b0, 1'b0, 1'b0, 2);
    enable = 1'b1;
    step();
    check_period(2, 6);

    // N=255
    div_req = 1'b1; div_val = 8'd255;
    step();
    check_hs("req255", 1'b1, 1'b0, 1'b1, 2);
    div_req = 1'b0;
    step();
    check_hs("app255", 1'b0, 1'b0, 1'b0, 255);
    check_period(255, 510);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
